// File: rtl/rob_retire_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire_ctrl
// Description : In-order retire controller downstream of the ROB; store
//               commit handshake, exception-to-trap conversion, instret.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_retire_ctrl #(
    parameter int RETIRE_RATE = 2,
    parameter int PC_LEN      = 64,
    parameter int ECAUSE_LEN  = 5,
    parameter int CNT_LEN     = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [RETIRE_RATE-1:0]            head_valid,
    input  logic [RETIRE_RATE-1:0]            head_busy,
    input  logic [RETIRE_RATE-1:0]            head_exc,
    input  logic [RETIRE_RATE-1:0]            head_is_store,
    input  logic [RETIRE_RATE*ECAUSE_LEN-1:0] head_ecause,
    input  logic [RETIRE_RATE*PC_LEN-1:0]     head_pc,
    input  logic                              st_commit_ready,
    output logic                              st_commit_valid,
    output logic [$clog2(RETIRE_RATE):0]      retire_cnt,
    output logic                              flush,
    output logic                              trap_valid,
    output logic [PC_LEN-1:0]                 trap_pc,
    output logic [ECAUSE_LEN-1:0]             trap_cause,
    output logic [CNT_LEN-1:0]                instret
);

    localparam int CW = $clog2(RETIRE_RATE) + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PC_LEN-1:0]       trap_pc_q, trap_pc_d;
    logic [ECAUSE_LEN-1:0]   trap_cause_q, trap_cause_d;
    logic [CNT_LEN-1:0]      instret_q;

    logic [CW-1:0]           w_scan_cnt;
    logic                    w_scan_st_valid;
    logic                    w_scan_exc;
    logic [PC_LEN-1:0]       w_exc_pc;
    logic [ECAUSE_LEN-1:0]   w_exc_cause;
    logic                    w_stop;
    logic                    w_store_seen;

    // In-order scan: stops at the first slot that cannot retire; at most
    // one store may commit per cycle.
    always_comb begin
        w_scan_cnt      = '0;
        w_scan_st_valid = 1'b0;
        w_scan_exc      = 1'b0;
        w_exc_pc        = '0;
        w_exc_cause     = '0;
        w_stop          = 1'b0;
        w_store_seen    = 1'b0;
        for (int i = 0; i < RETIRE_RATE; i++) begin
            if (!w_stop) begin
                if (head_valid[i] && !head_busy[i] && head_exc[i]) begin
                    w_scan_exc  = 1'b1;
                    w_exc_pc    = head_pc[i*PC_LEN +: PC_LEN];
                    w_exc_cause = head_ecause[i*ECAUSE_LEN +: ECAUSE_LEN];
                    w_stop      = 1'b1;
                end else if (!head_valid[i] || head_busy[i]) begin
                    w_stop = 1'b1;
                end else if (head_is_store[i]) begin
                    if (w_store_seen) begin
                        w_stop = 1'b1;
                    end else begin
                        w_store_seen    = 1'b1;
                        w_scan_st_valid = 1'b1;
                        if (st_commit_ready) begin
                            w_scan_cnt = w_scan_cnt + CW'(1);
                        end else begin
                            w_stop = 1'b1;
                        end
                    end
                end else begin
                    w_scan_cnt = w_scan_cnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        trap_pc_d       = trap_pc_q;
        trap_cause_d    = trap_cause_q;
        retire_cnt      = '0;
        st_commit_valid = 1'b0;
        flush           = 1'b0;
        trap_valid      = 1'b0;
        case (state_q)
            RUN: begin
                retire_cnt      = w_scan_cnt;
                st_commit_valid = w_scan_st_valid;
                if (w_scan_exc) begin
                    trap_pc_d    = w_exc_pc;
                    trap_cause_d = w_exc_cause;
                    state_d      = TRAP;
                end
            end
            TRAP: begin
                flush      = 1'b1;
                trap_valid = 1'b1;
                state_d    = DRAIN;
            end
            DRAIN:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            trap_pc_q    <= '0;
            trap_cause_q <= '0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            trap_pc_q    <= trap_pc_d;
            trap_cause_q <= trap_cause_d;
            instret_q    <= instret_q + CNT_LEN'(retire_cnt);
        end
    end

    assign trap_pc    = trap_pc_q;
    assign trap_cause = trap_cause_q;
    assign instret    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_retire_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_retire_ctrl
// Description : Directed self-checking bench for rob_retire_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_retire_ctrl;

    logic         clk;
    logic         rst;
    logic [1:0]   head_valid;
    logic [1:0]   head_busy;
    logic [1:0]   head_exc;
    logic [1:0]   head_is_store;
    logic [9:0]   head_ecause;
    logic [127:0] head_pc;
    logic         st_commit_ready;
    logic         st_commit_valid;
    logic [1:0]   retire_cnt;
    logic         flush;
    logic         trap_valid;
    logic [63:0]  trap_pc;
    logic [4:0]   trap_cause;
    logic [63:0]  instret;

    int r_errors = 0;
    int r_checks = 0;

    rob_retire_ctrl #(
        .RETIRE_RATE(2),
        .PC_LEN     (64),
        .ECAUSE_LEN (5),
        .CNT_LEN    (64)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .head_valid     (head_valid),
        .head_busy      (head_busy),
        .head_exc       (head_exc),
        .head_is_store  (head_is_store),
        .head_ecause    (head_ecause),
        .head_pc        (head_pc),
        .st_commit_ready(st_commit_ready),
        .st_commit_valid(st_commit_valid),
        .retire_cnt     (retire_cnt),
        .flush          (flush),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .instret        (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then leave a settle gap before new inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic heads(input logic [1:0] v, input logic [1:0] b,
                         input logic [1:0] e, input logic [1:0] s, input logic rdy);
        head_valid      = v;
        head_busy       = b;
        head_exc        = e;
        head_is_store   = s;
        st_commit_ready = rdy;
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".flush"}, 64'(flush), 64'd0);
        check({tag, ".trap_valid"}, 64'(trap_valid), 64'd0);
        check({tag, ".retire_cnt"}, 64'(retire_cnt), 64'd0);
        check({tag, ".st_valid"}, 64'(st_commit_valid), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        head_ecause = '0;
        head_pc     = '0;
        heads(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_idle("reset");
        check("reset.instret", instret, 64'd0);
        check("reset.trap_pc", trap_pc, 64'd0);
        check("reset.trap_cause", 64'(trap_cause), 64'd0);

        // Two plain instructions per cycle
        heads(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        check("dual.cnt", 64'(retire_cnt), 64'd2);
        tick();
        check("dual.instret1", instret, 64'd2);
        tick();
        check("dual.instret2", instret, 64'd4);

        // Younger slot busy, then older slot busy
        heads(2'b11, 2'b10, 2'b00, 2'b00, 1'b0);
        check("s1busy.cnt", 64'(retire_cnt), 64'd1);
        tick();
        check("s1busy.instret", instret, 64'd5);
        heads(2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        check("s0busy.cnt", 64'(retire_cnt), 64'd0);
        tick();
        check("s0busy.instret", instret, 64'd5);

        // Two stores: only one commits per cycle
        heads(2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
        check("st2rdy.cnt", 64'(retire_cnt), 64'd1);
        check("st2rdy.valid", 64'(st_commit_valid), 64'd1);
        tick();
        check("st2rdy.instret", instret, 64'd6);
        heads(2'b11, 2'b00, 2'b00, 2'b11, 1'b0);
        check("stnrdy.cnt", 64'(retire_cnt), 64'd0);
        check("stnrdy.valid", 64'(st_commit_valid), 64'd1);
        tick();
        check("stnrdy.instret", instret, 64'd6);

        // Plain then store with ready: both retire
        heads(2'b11, 2'b00, 2'b00, 2'b10, 1'b1);
        check("ldst.cnt", 64'(retire_cnt), 64'd2);
        check("ldst.valid", 64'(st_commit_valid), 64'd1);
        tick();
        check("ldst.instret", instret, 64'd8);

        // Exception in slot 1
        head_pc[127:64] = 64'h8000_0010;
        head_ecause[9:5] = 5'd2;
        heads(2'b11, 2'b00, 2'b10, 2'b00, 1'b0);
        check("exc1.cnt", 64'(retire_cnt), 64'd1);
        check("exc1.flush", 64'(flush), 64'd0);
        tick();
        check("trap.flush", 64'(flush), 64'd1);
        check("trap.trap_valid", 64'(trap_valid), 64'd1);
        check("trap.pc", trap_pc, 64'h8000_0010);
        check("trap.cause", 64'(trap_cause), 64'd2);
        check("trap.cnt", 64'(retire_cnt), 64'd0);
        check("trap.instret", instret, 64'd9);
        tick();
        chk_idle("drain");
        check("drain.instret", instret, 64'd9);
        tick();
        heads(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        check("resume.cnt", 64'(retire_cnt), 64'd2);
        tick();
        check("resume.instret", instret, 64'd11);

        // Empty head
        heads(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        check("empty.cnt", 64'(retire_cnt), 64'd0);

        // Excepting slot 0 still busy: no trap until busy clears
        head_pc[63:0]  = 64'h1234;
        head_ecause[4:0] = 5'd7;
        heads(2'b01, 2'b01, 2'b01, 2'b00, 1'b0);
        check("excbusy.cnt", 64'(retire_cnt), 64'd0);
        tick();
        check("excbusy.flush", 64'(flush), 64'd0);
        check("excbusy.pc_hold", trap_pc, 64'h8000_0010);
        heads(2'b01, 2'b00, 2'b01, 2'b00, 1'b0);
        check("exc0.cnt", 64'(retire_cnt), 64'd0);
        check("exc0.flush", 64'(flush), 64'd0);
        tick();
        check("exc0.flush1", 64'(flush), 64'd1);
        check("exc0.pc", trap_pc, 64'h1234);
        check("exc0.cause", 64'(trap_cause), 64'd7);
        check("exc0.instret", instret, 64'd11);

        // Reset while in TRAP
        rst = 1'b1;
        heads(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("rsttrap.flush", 64'(flush), 64'd0);
        check("rsttrap.trap_valid", 64'(trap_valid), 64'd0);
        check("rsttrap.instret", instret, 64'd0);
        check("rsttrap.pc", trap_pc, 64'd0);
        check("rsttrap.run_cnt", 64'(retire_cnt), 64'd2);
        tick();
        check("rsttrap.instret2", instret, 64'd2);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
